// File: rtl/opc_sysbus_if.sv
// rtl/opc_sysbus_if.sv - CPU-side request/ready bus between an OPC-class CPU and opc_sysbus
interface opc_sysbus_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_rnw;
  logic              cpu_req;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ready;

  modport master (
    output cpu_addr, cpu_wdata, cpu_rnw, cpu_req,
    input  cpu_rdata, cpu_ready
  );

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_rnw, cpu_req,
    output cpu_rdata, cpu_ready
  );
endinterface

// File: rtl/opc_sysbus.sv
// rtl/opc_sysbus.sv - system bus controller: RAM region, ack/wait I/O slots, access timeout, sticky error
module opc_sysbus #(
  parameter int                ADDR_W       = 16,
  parameter int                DATA_W       = 16,
  parameter int                RAMSIZE      = 11,
  parameter logic [ADDR_W-1:0] IO_BASE      = 16'hFE00,
  parameter int                NUM_IO       = 4,
  parameter int                IO_SLOT_BITS = 3,
  parameter int                TIMEOUT      = 15
) (
  input  logic                     clk,
  input  logic                     reset_b,
  opc_sysbus_if.slave              bus,
  output logic                     ram_cs_b,
  input  logic [DATA_W-1:0]        ram_rdata,
  output logic [NUM_IO-1:0]        io_cs_b,
  output logic [IO_SLOT_BITS-1:0]  io_addr,
  output logic [DATA_W-1:0]        io_wdata,
  output logic                     io_rnw,
  input  logic [NUM_IO*DATA_W-1:0] io_rdata,
  input  logic [NUM_IO-1:0]        io_ack,
  input  logic                     err_clr,
  output logic                     bus_err
);
  localparam int              SLOT_W    = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;
  localparam int              HI_W      = ADDR_W - IO_SLOT_BITS;
  localparam logic [HI_W-1:0] NUM_IO_HI = HI_W'(NUM_IO);
  localparam logic [7:0]      LAST_WAIT = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, IO_WAIT, DONE} state_t;

  state_t            state, state_nxt;
  logic [SLOT_W-1:0] slot_q;
  logic [DATA_W-1:0] rdata_q;
  logic [7:0]        wait_cnt;

  logic [ADDR_W-1:0] io_off;
  logic              is_ram, is_io;
  logic [SLOT_W-1:0] slot_dec;
  logic              ack_sel;
  logic [DATA_W-1:0] io_rdata_sel;
  logic              start_io, unmapped_hit, timeout_hit;

  // Decode the live CPU address; RAM wins wherever it overlaps the I/O window.
  always_comb begin
    io_off   = bus.cpu_addr - IO_BASE;
    is_ram   = (bus.cpu_addr >> RAMSIZE) == '0;
    is_io    = !is_ram && (bus.cpu_addr >= IO_BASE) &&
               (io_off[ADDR_W-1:IO_SLOT_BITS] < NUM_IO_HI);
    slot_dec = io_off[IO_SLOT_BITS +: SLOT_W];
  end

  // Only the latched slot's strobe and read word matter; other slots are ignored.
  always_comb begin
    ack_sel      = 1'b0;
    io_rdata_sel = '1;
    for (int i = 0; i < NUM_IO; i++) begin
      if (slot_q == SLOT_W'(i)) begin
        ack_sel      = io_ack[i];
        io_rdata_sel = io_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign start_io     = (state == IDLE) && bus.cpu_req && is_io;
  assign unmapped_hit = (state == IDLE) && bus.cpu_req && !is_ram && !is_io;
  assign timeout_hit  = (state == IO_WAIT) && !ack_sel && (wait_cnt == LAST_WAIT);

  // State register.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state: RAM and unmapped accesses finish in IDLE, I/O goes through IO_WAIT and DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_io) state_nxt = IO_WAIT;
      IO_WAIT: if (ack_sel || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: chip selects, ready and read-data steering; RAM select is held off during reset.
  always_comb begin
    ram_cs_b      = 1'b1;
    io_cs_b       = '1;
    bus.cpu_ready = 1'b1;
    bus.cpu_rdata = '1;
    case (state)
      IDLE: begin
        if (bus.cpu_req) begin
          if (is_ram) begin
            ram_cs_b      = !reset_b;
            bus.cpu_rdata = ram_rdata;
          end else if (is_io) begin
            bus.cpu_ready = 1'b0;
          end
        end
      end
      IO_WAIT: begin
        bus.cpu_ready = 1'b0;
        for (int i = 0; i < NUM_IO; i++) begin
          io_cs_b[i] = (slot_q != SLOT_W'(i));
        end
      end
      DONE: begin
        bus.cpu_rdata = rdata_q;
      end
      default: ;
    endcase
  end

  // I/O datapath: capture the request on entry, count wait cycles, capture the result on exit.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      slot_q   <= '0;
      io_addr  <= '0;
      io_wdata <= '0;
      io_rnw   <= 1'b1;
      rdata_q  <= '1;
      wait_cnt <= '0;
    end else if (start_io) begin
      slot_q   <= slot_dec;
      io_addr  <= io_off[IO_SLOT_BITS-1:0];
      io_wdata <= bus.cpu_wdata;
      io_rnw   <= bus.cpu_rnw;
      wait_cnt <= '0;
    end else if (state == IO_WAIT) begin
      if (ack_sel)          rdata_q  <= io_rdata_sel;
      else if (timeout_hit) rdata_q  <= '1;
      else                  wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Sticky error flag; a new fault in the same cycle beats the clear.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b)                        bus_err <= 1'b0;
    else if (unmapped_hit || timeout_hit) bus_err <= 1'b1;
    else if (err_clr)                    bus_err <= 1'b0;
  end
endmodule

// File: tb/tb_opc_sysbus.sv
// tb/tb_opc_sysbus.sv - scoreboard bench for opc_sysbus with RAM and I/O slot models
module tb_opc_sysbus;
  logic        clk = 1'b0;
  logic        reset_b = 1'b0;
  logic        ram_cs_b;
  logic [15:0] ram_rdata;
  logic [3:0]  io_cs_b;
  logic [2:0]  io_addr;
  logic [15:0] io_wdata;
  logic        io_rnw;
  logic [63:0] io_rdata;
  logic [3:0]  io_ack;
  logic        err_clr;
  logic        bus_err;

  opc_sysbus_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  opc_sysbus dut (
    .clk       (clk),
    .reset_b   (reset_b),
    .bus       (bus),
    .ram_cs_b  (ram_cs_b),
    .ram_rdata (ram_rdata),
    .io_cs_b   (io_cs_b),
    .io_addr   (io_addr),
    .io_wdata  (io_wdata),
    .io_rnw    (io_rnw),
    .io_rdata  (io_rdata),
    .io_ack    (io_ack),
    .err_clr   (err_clr),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // RAM model, written on the falling edge.
  logic [15:0] mem [0:2047];
  assign ram_rdata = mem[bus.cpu_addr[10:0]];

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
    forever begin
      @(negedge clk);
      if (!ram_cs_b && !bus.cpu_rnw) mem[bus.cpu_addr[10:0]] = bus.cpu_wdata;
    end
  end

  // I/O slot model: slot ack_slot acks after ack_k wait cycles; slot 2 may ack spuriously.
  int          ack_slot = -1;
  int          ack_k = 0;
  logic        spur = 1'b0;
  int          wait_seen = 0;
  logic [3:0]  cap_cs;
  logic [2:0]  cap_addr;
  logic [15:0] cap_wd;
  logic        cap_rnw;
  logic        unstable;

  initial begin
    io_ack   = 4'h0;
    io_rdata = {16'h5A03, 16'h5A02, 16'hABCD, 16'h5A00};
    forever begin
      @(negedge clk);
      if (io_cs_b !== 4'hF) begin
        if (wait_seen == 0) begin
          cap_cs = io_cs_b; cap_addr = io_addr; cap_wd = io_wdata; cap_rnw = io_rnw;
          unstable = 1'b0;
        end else if (io_cs_b !== cap_cs || io_addr !== cap_addr ||
                     io_wdata !== cap_wd || io_rnw !== cap_rnw) begin
          unstable = 1'b1;
        end
        wait_seen++;
        io_ack = 4'h0;
        if (ack_slot >= 0 && wait_seen == ack_k + 1) io_ack[ack_slot] = 1'b1;
        if (spur) io_ack[2] = 1'b1;
      end else begin
        wait_seen = 0;
        io_ack    = 4'h0;
      end
    end
  end

  typedef struct {
    logic [15:0] rdata;
    logic        chk_rd;
    int          cycles;
    logic        ramcs;
  } exp_t;

  exp_t exp_q[$];

  // Push the expectation, run the access until ready, pop and compare.
  task automatic access(input string tag, input logic [15:0] a, input logic [15:0] wd,
                        input logic rnw, input logic [15:0] exp_rd, input int exp_cyc,
                        input logic exp_ramcs);
    int          cyc;
    logic        done;
    logic [15:0] got_rd;
    logic        got_ramcs;
    exp_t        e;
    exp_q.push_back('{rdata: exp_rd, chk_rd: rnw, cycles: exp_cyc, ramcs: exp_ramcs});
    bus.cpu_addr = a; bus.cpu_wdata = wd; bus.cpu_rnw = rnw; bus.cpu_req = 1'b1;
    cyc = 0; done = 1'b0; got_rd = '0; got_ramcs = 1'b1;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus.cpu_ready) begin
        done = 1'b1; got_rd = bus.cpu_rdata; got_ramcs = ram_cs_b;
      end
    end
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
    e = exp_q.pop_front();
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_cycles"}, cyc, e.cycles);
    chk({tag, "_ramcs"}, {31'd0, got_ramcs}, {31'd0, e.ramcs});
    if (e.chk_rd) chk({tag, "_rdata"}, {16'd0, got_rd}, {16'd0, e.rdata});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_rnw = 1'b1; bus.cpu_req = 1'b0;
    err_clr = 1'b0;
    #23 reset_b = 1'b1;
    @(negedge clk);
    chk("rst_ram_cs", {31'd0, ram_cs_b}, 32'd1);
    chk("rst_io_cs", {28'd0, io_cs_b}, 32'hF);
    chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
    chk("rst_ready", {31'd0, bus.cpu_ready}, 32'd1);
    chk("rst_rdata", {16'd0, bus.cpu_rdata}, 32'hFFFF);
    chk("rst_io_addr", {29'd0, io_addr}, 32'd0);
    chk("rst_io_wdata", {16'd0, io_wdata}, 32'd0);
    chk("rst_io_rnw", {31'd0, io_rnw}, 32'd1);
    @(posedge clk); #1;

    access("ram_wr", 16'h0010, 16'h1234, 1'b0, 16'h0000, 1, 1'b0);
    access("ram_rd", 16'h0010, 16'h0000, 1'b1, 16'h1234, 1, 1'b0);
    access("unmapped", 16'h0800, 16'h0000, 1'b1, 16'hFFFF, 1, 1'b1);
    @(negedge clk);
    chk("unmapped_err", {31'd0, bus_err}, 32'd1);
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    @(negedge clk);
    chk("clr1_err", {31'd0, bus_err}, 32'd0);
    @(posedge clk); #1;

    ack_slot = 1; ack_k = 2;
    access("io_rd1", 16'hFE09, 16'h0000, 1'b1, 16'hABCD, 5, 1'b1);
    chk("io_rd1_cs", {28'd0, cap_cs}, 32'b1101);
    chk("io_rd1_addr", {29'd0, cap_addr}, 32'd1);
    chk("io_rd1_rnw", {31'd0, cap_rnw}, 32'd1);
    chk("io_rd1_stable", {31'd0, unstable}, 32'd0);

    ack_slot = 3; ack_k = 0;
    access("io_wr3", 16'hFE1F, 16'h00FF, 1'b0, 16'h0000, 3, 1'b1);
    chk("io_wr3_cs", {28'd0, cap_cs}, 32'b0111);
    chk("io_wr3_wdata", {16'd0, cap_wd}, 32'h00FF);
    chk("io_wr3_rnw", {31'd0, cap_rnw}, 32'd0);
    chk("io_wr3_addr", {29'd0, cap_addr}, 32'd7);
    chk("io_wr3_stable", {31'd0, unstable}, 32'd0);
    chk("io_wr3_err", {31'd0, bus_err}, 32'd0);

    ack_slot = -1; spur = 1'b1;
    access("timeout", 16'hFE00, 16'h0000, 1'b1, 16'hFFFF, 17, 1'b1);
    spur = 1'b0;
    chk("timeout_cs", {28'd0, cap_cs}, 32'b1110);
    @(negedge clk);
    chk("timeout_err", {31'd0, bus_err}, 32'd1);
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    @(negedge clk);
    chk("clr2_err", {31'd0, bus_err}, 32'd0);
    @(posedge clk); #1;
    err_clr = 1'b1;
    access("clr_vs_set", 16'h0800, 16'h0000, 1'b1, 16'hFFFF, 1, 1'b1);
    err_clr = 1'b0;
    @(negedge clk);
    chk("clr_vs_set_err", {31'd0, bus_err}, 32'd1);
    @(posedge clk); #1;

    ack_slot = -1;
    bus.cpu_addr = 16'hFE00; bus.cpu_rnw = 1'b1; bus.cpu_req = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("mid_cs_before", {28'd0, io_cs_b}, 32'b1110);
    reset_b = 1'b0;
    #1;
    chk("mid_cs_async", {28'd0, io_cs_b}, 32'hF);
    bus.cpu_req = 1'b0;
    #3 reset_b = 1'b1;
    @(negedge clk);
    chk("mid_ready", {31'd0, bus.cpu_ready}, 32'd1);
    chk("mid_err", {31'd0, bus_err}, 32'd0);
    @(posedge clk); #1;
    access("post_rst_ram", 16'h0010, 16'h0000, 1'b1, 16'h1234, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
